// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck
  } state_e;

  localparam logic RW_WRITE = 1'b1;

  // A frame is one R/W bit, then the address field, then the data field.
  function automatic int unsigned frame_len(int unsigned addr_w, int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle: slave modport for the peripheral, master modport for whoever drives the bus.
interface spi_regfile_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport slave (
    input  sclk,
    input  copi,
    input  ncs,
    output cipo,
    output cipo_oe
  );

  modport master (
    output sclk,
    output copi,
    output ncs,
    input  cipo,
    input  cipo_oe
  );
endinterface

// File: rtl/spi_edge_sync.sv
// Three-stage synchroniser with level, rise and fall outputs for an asynchronous input.
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], sig};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file slave with framed writes and address validation.
// Optional read-back of registers on cipo is enabled by defining SPI_READBACK_EN.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int unsigned       NUM_REGS  = 5,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 7,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       err_pulse
);

  localparam int unsigned FrameLen = frame_len(ADDR_W, DATA_W);
  localparam int unsigned CntW     = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameLen);
  localparam logic [CntW-1:0] CntMax  = CntW'(FrameLen + 1);
  localparam logic [CntW-1:0] CntAddr = CntW'(1 + ADDR_W);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic [1:0] copi_q;
  logic       copi_sync;

  spi_edge_sync #(.RESET_VAL(1'b1)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (spi.sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_edge_sync #(.RESET_VAL(1'b1)) u_ncs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (spi.ncs),
    .level (ncs_lvl),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copi_q <= 2'b00;
    end else begin
      copi_q <= {copi_q[0], spi.copi};
    end
  end
  assign copi_sync = copi_q[1];

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_next;
  logic [FrameLen-1:0]  shift_q, shift_d, shift_next;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic                 armed_q, armed_d;
  logic [1:0]           settle_q, settle_d;
  logic                 settled;
  logic                 wr_strobe_q, err_q, err_d, commit;
  logic [ADDR_W-1:0]    wr_addr_q;

  logic                 sample, overrun, short_frame, addr_ok, frame_ok, read_ok, rw_bit;
  logic [ADDR_W-1:0]    addr_f;
  logic [DATA_W-1:0]    data_f;

  // The ncs synchroniser resets high, so its first post-reset samples are not trusted;
  // a frame may only start after ncs has genuinely been seen high.
  assign settled  = settle_q[1];
  assign settle_d = settled ? settle_q : settle_q + 2'd1;

  assign sample     = (state_q == StShift) & sclk_rise & ~ncs_lvl;
  assign shift_next = {shift_q[FrameLen-2:0], copi_sync};
  assign cnt_next   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  assign rw_bit      = shift_q[FrameLen-1];
  assign addr_f      = shift_q[FrameLen-2 -: ADDR_W];
  assign data_f      = shift_q[DATA_W-1:0];
  assign overrun     = cnt_q > CntFull;
  assign short_frame = cnt_q < CntFull;
  assign addr_ok     = 32'(addr_f) < NUM_REGS;
  assign frame_ok    = ~overrun & ~short_frame & addr_ok;
`ifdef SPI_READBACK_EN
  assign read_ok     = frame_ok & (rw_bit != RW_WRITE);
`else
  assign read_ok     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    armed_d = armed_q | (settled & ncs_lvl);
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // Level check also recovers an ncs fall that arrived while in StCheck.
        if (armed_q && (ncs_fall || !ncs_lvl)) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
          armed_d = 1'b0;
        end
      end
      StShift: begin
        if (ncs_rise) begin
          state_d = StCheck;
        end else if (sample) begin
          shift_d = shift_next;
          cnt_d   = cnt_next;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (frame_ok && rw_bit == RW_WRITE) begin
          commit = 1'b1;
        end else if (!read_ok) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (commit && 32'(addr_f) == i) begin
        regs_d[i] = data_f;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      settle_q    <= 2'b00;
      regs_q      <= '{default: RESET_VAL};
      wr_strobe_q <= 1'b0;
      err_q       <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      settle_q    <= settle_d;
      regs_q      <= regs_d;
      wr_strobe_q <= commit;
      err_q       <= err_d;
      if (commit) begin
        wr_addr_q <= addr_f;
      end
    end
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_out[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign wr_strobe = wr_strobe_q;
  assign err_pulse = err_q;
  assign wr_addr   = wr_addr_q;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_q, tx_d, rd_sel;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] rd_addr;

  // Address as it stands once the sample in progress lands in the shift register.
  assign rd_addr = shift_next[ADDR_W-1:0];

  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_addr) == i) begin
        rd_sel = regs_q[i];
      end
    end
  end

  always_comb begin
    tx_d = tx_q;
    oe_d = oe_q;
    if (state_q != StShift || ncs_rise) begin
      oe_d = 1'b0;
    end else if (sample && cnt_next == CntAddr && shift_next[ADDR_W] != RW_WRITE) begin
      if (32'(rd_addr) < NUM_REGS) begin
        tx_d = rd_sel;
        oe_d = 1'b1;
      end else begin
        tx_d = '0;
      end
    end else if (sclk_fall && oe_q && cnt_q > CntAddr) begin
      // The fall before the first data rise keeps the MSB on the line.
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      oe_q <= 1'b0;
    end else begin
      tx_q <= tx_d;
      oe_q <= oe_d;
    end
  end

  assign spi.cipo    = oe_q & tx_q[DATA_W-1];
  assign spi.cipo_oe = oe_q;
`else
  assign spi.cipo    = 1'b0;
  assign spi.cipo_oe = 1'b0;
`endif

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_fall};

endmodule
